// File: rtl/sci_pkg.sv
// Shared SCI initiator definitions: FSM state codes, WNR encoding and frame length.
package sci_pkg;

   typedef logic [2:0] sci_state_t;

   localparam sci_state_t ST_IDLE      = 3'd0;
   localparam sci_state_t ST_SEND      = 3'd1;
   localparam sci_state_t ST_WAIT_ACK  = 3'd2;
   localparam sci_state_t ST_READ_DATA = 3'd3;
   localparam sci_state_t ST_DONE      = 3'd4;

   localparam logic WNR_WRITE = 1'b1;
   localparam logic WNR_READ  = 1'b0;

   function automatic int frame_len(input logic wnr, input int addr_w, input int data_w);
      if (wnr == WNR_WRITE) begin
         return 1 + addr_w + data_w;
      end else begin
         return 1 + addr_w;
      end
   endfunction

endpackage

// File: rtl/sci_if.sv
// Host request/response handshake plus the SCI serial lines of one initiator.
interface sci_if #(
   parameter int NUM_PERIPHERALS = 9,
   parameter int ADDR_WIDTH      = 4,
   parameter int DATA_WIDTH      = 8
);
   localparam int PW = (NUM_PERIPHERALS > 1) ? $clog2(NUM_PERIPHERALS) : 1;

   logic                       REQ_VALID;
   logic                       REQ_READY;
   logic                       REQ_WNR;
   logic [PW-1:0]              REQ_PERIPH;
   logic [ADDR_WIDTH-1:0]      REQ_ADDR;
   logic [DATA_WIDTH-1:0]      REQ_WDATA;
   logic                       RSP_VALID;
   logic [DATA_WIDTH-1:0]      RSP_RDATA;
   logic                       RSP_ERROR;
   logic [NUM_PERIPHERALS-1:0] SCI_CSN;
   logic                       SCI_REQ;
   logic                       SCI_RESP;
   logic                       SCI_ACK;

   modport master (
      input  REQ_VALID, REQ_WNR, REQ_PERIPH, REQ_ADDR, REQ_WDATA, SCI_RESP, SCI_ACK,
      output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERROR, SCI_CSN, SCI_REQ
   );

   modport slave (
      output REQ_VALID, REQ_WNR, REQ_PERIPH, REQ_ADDR, REQ_WDATA, SCI_RESP, SCI_ACK,
      input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERROR, SCI_CSN, SCI_REQ
   );
endinterface

// File: rtl/sci_shifter.sv
// MSB-first shift register with a saturating shift counter; parallel load, serial in at the LSB.
module sci_shifter #(
   parameter int WIDTH = 8
) (
   input  logic                           CLK,
   input  logic                           RST,
   input  logic                           load,
   input  logic [WIDTH-1:0]               load_data,
   input  logic                           shift,
   input  logic                           ser_in,
   output logic [WIDTH-1:0]               par_out,
   output logic [$clog2(WIDTH+1)-1:0]     cnt
);
   localparam int CW = $clog2(WIDTH+1);

   logic [WIDTH-1:0] data_q, data_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   // Load has priority over shift; the counter restarts on every load.
   always_comb begin
      data_d = data_q;
      cnt_d  = cnt_q;
      if (load) begin
         data_d = load_data;
         cnt_d  = {CW{1'b0}};
      end else if (shift) begin
         data_d = {data_q[WIDTH-2:0], ser_in};
         cnt_d  = (cnt_q == CW'(WIDTH)) ? cnt_q : cnt_q + CW'(1);
      end else begin
         data_d = data_q;
         cnt_d  = cnt_q;
      end
   end

   // State registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         data_q <= {WIDTH{1'b0}};
         cnt_q  <= {CW{1'b0}};
      end else begin
         data_q <= data_d;
         cnt_q  <= cnt_d;
      end
   end

   assign par_out = data_q;
   assign cnt     = cnt_q;
endmodule

// File: rtl/sci_initiator.sv
// SCI bus master: serialises one host read/write to a selected neuron and returns one response.
module sci_initiator
   import sci_pkg::*;
#(
   parameter int NUM_PERIPHERALS = 9,
   parameter int ADDR_WIDTH      = 4,
   parameter int DATA_WIDTH      = 8,
   parameter int TIMEOUT_CYCLES  = 64
) (
   input logic   CLK,
   input logic   RST,
   sci_if.master bus
);
   localparam int TXW = 1 + ADDR_WIDTH + DATA_WIDTH;
   localparam int TXC = $clog2(TXW + 1);
   localparam int RXC = $clog2(DATA_WIDTH + 1);
   localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TCW-1:0]             TMO_MAX  = TCW'(TIMEOUT_CYCLES);
   localparam logic [NUM_PERIPHERALS-1:0] CSN_IDLE = {NUM_PERIPHERALS{1'b1}};
   localparam logic [NUM_PERIPHERALS-1:0] CSN_ONE  = NUM_PERIPHERALS'(1'b1);

   sci_state_t                 state_q, state_d;
   logic                       wnr_q, wnr_d;
   logic                       bad_q, bad_d;
   logic [TCW-1:0]             tmo_q, tmo_d, tmo_inc_s;
   logic [NUM_PERIPHERALS-1:0] csn_q, csn_d;
   logic                       sci_req_q, sci_req_d;
   logic                       rsp_valid_q, rsp_valid_d;
   logic                       rsp_error_q, rsp_error_d;
   logic [DATA_WIDTH-1:0]      rsp_rdata_q, rsp_rdata_d;

   logic                  ready_s, accept_s, req_bad_s, tx_last_s, done_s, done_err_s;
   logic                  tx_load_s, tx_shift_s, rx_load_s, rx_shift_s;
   logic [TXW-1:0]        tx_frame_s, tx_par_s;
   logic [TXC-1:0]        tx_cnt_s;
   logic [DATA_WIDTH-1:0] rx_par_s;
   logic [RXC-1:0]        rx_cnt_s;
   logic                  unused_s;

   assign ready_s    = (state_q == ST_IDLE) && !RST;
   assign accept_s   = bus.REQ_VALID && ready_s;
   assign req_bad_s  = int'(bus.REQ_PERIPH) >= NUM_PERIPHERALS;
   assign tx_frame_s = {bus.REQ_WNR, bus.REQ_ADDR,
                        (bus.REQ_WNR == WNR_WRITE) ? bus.REQ_WDATA : {DATA_WIDTH{1'b0}}};
   assign tx_last_s  = (tx_cnt_s == TXC'(frame_len(wnr_q, ADDR_WIDTH, DATA_WIDTH) - 1));
   // Frame MSB is driven straight from the request; the shifter supplies the bit after it.
   assign unused_s   = ^{tx_par_s[TXW-1], tx_par_s[TXW-3:0], rx_par_s[DATA_WIDTH-1]};

   sci_shifter #(.WIDTH(TXW)) u_tx (
      .CLK(CLK), .RST(RST), .load(tx_load_s), .load_data(tx_frame_s),
      .shift(tx_shift_s), .ser_in(1'b0), .par_out(tx_par_s), .cnt(tx_cnt_s)
   );

   sci_shifter #(.WIDTH(DATA_WIDTH)) u_rx (
      .CLK(CLK), .RST(RST), .load(rx_load_s), .load_data({DATA_WIDTH{1'b0}}),
      .shift(rx_shift_s), .ser_in(bus.SCI_RESP), .par_out(rx_par_s), .cnt(rx_cnt_s)
   );

   // Next-state, chip-select, serial-out and response decode.
   always_comb begin
      state_d     = state_q;
      wnr_d       = wnr_q;
      bad_d       = bad_q;
      csn_d       = csn_q;
      sci_req_d   = 1'b0;
      tmo_d       = {TCW{1'b0}};
      tmo_inc_s   = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TCW'(1);
      rsp_valid_d = 1'b0;
      rsp_error_d = 1'b0;
      rsp_rdata_d = {DATA_WIDTH{1'b0}};
      tx_load_s   = 1'b0;
      tx_shift_s  = 1'b0;
      rx_load_s   = 1'b0;
      rx_shift_s  = 1'b0;
      done_s      = 1'b0;
      done_err_s  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               wnr_d     = bus.REQ_WNR;
               bad_d     = req_bad_s;
               tx_load_s = 1'b1;
               rx_load_s = 1'b1;
               state_d   = ST_SEND;
               if (req_bad_s) begin
                  csn_d = CSN_IDLE;
               end else begin
                  csn_d     = ~(CSN_ONE << bus.REQ_PERIPH);
                  sci_req_d = bus.REQ_WNR;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SEND: begin
            if (bad_q) begin
               done_s     = 1'b1;
               done_err_s = 1'b1;
            end else if (tx_last_s) begin
               state_d = ST_WAIT_ACK;
            end else begin
               tx_shift_s = 1'b1;
               sci_req_d  = tx_par_s[TXW-2];
            end
         end
         ST_WAIT_ACK: begin
            if (bus.SCI_ACK) begin
               if (wnr_q == WNR_WRITE) begin
                  done_s = 1'b1;
               end else begin
                  rx_shift_s = 1'b1;
                  state_d    = ST_READ_DATA;
               end
            end else if (tmo_inc_s == TMO_MAX) begin
               done_s     = 1'b1;
               done_err_s = 1'b1;
            end else begin
               tmo_d = tmo_inc_s;
            end
         end
         ST_READ_DATA: begin
            // Every remaining data bit must arrive with ACK; a gap breaks the burst.
            if (bus.SCI_ACK) begin
               rx_shift_s = 1'b1;
               if (rx_cnt_s == RXC'(DATA_WIDTH - 1)) begin
                  done_s      = 1'b1;
                  rsp_rdata_d = {rx_par_s[DATA_WIDTH-2:0], bus.SCI_RESP};
               end else begin
                  state_d = ST_READ_DATA;
               end
            end else begin
               done_s     = 1'b1;
               done_err_s = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            csn_d   = CSN_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            csn_d   = CSN_IDLE;
         end
      endcase
      if (done_s) begin
         state_d     = ST_DONE;
         csn_d       = CSN_IDLE;
         rsp_valid_d = 1'b1;
         rsp_error_d = done_err_s;
      end else begin
         rsp_valid_d = 1'b0;
      end
   end

   // State and output registers; reset abandons any frame in flight.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         wnr_q       <= 1'b0;
         bad_q       <= 1'b0;
         tmo_q       <= {TCW{1'b0}};
         csn_q       <= CSN_IDLE;
         sci_req_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_error_q <= 1'b0;
         rsp_rdata_q <= {DATA_WIDTH{1'b0}};
      end else begin
         state_q     <= state_d;
         wnr_q       <= wnr_d;
         bad_q       <= bad_d;
         tmo_q       <= tmo_d;
         csn_q       <= csn_d;
         sci_req_q   <= sci_req_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_error_q <= rsp_error_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign bus.REQ_READY = ready_s;
   assign bus.RSP_VALID = rsp_valid_q;
   assign bus.RSP_ERROR = rsp_error_q;
   assign bus.RSP_RDATA = rsp_rdata_q;
   assign bus.SCI_CSN   = csn_q;
   assign bus.SCI_REQ   = sci_req_q;
endmodule

// File: tb/tb_sci_initiator.sv
// Self-checking bench for sci_initiator: directed vector table, reset/idle sequences, random traffic.
module tb_sci_initiator;
   logic clk;
   logic rst;
   int   n_pass;
   int   n_total;

   sci_if #(.NUM_PERIPHERALS(9), .ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();

   sci_initiator #(
      .NUM_PERIPHERALS(9), .ADDR_WIDTH(4), .DATA_WIDTH(8), .TIMEOUT_CYCLES(64)
   ) dut (
      .CLK(clk), .RST(rst), .bus(bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      logic       wnr;
      logic [3:0] periph;
      logic [3:0] addr;
      logic [7:0] wdata;
      int         delay;
      int         nack;
      logic [7:0] rsrc;
      int         exp_cyc;
      logic       exp_err;
      logic [7:0] exp_rd;
   } vec_t;

   int          obs_cyc;
   logic        obs_err;
   logic [7:0]  obs_rdata;
   logic [12:0] obs_frame;
   logic        obs_ready0;
   int          obs_csn_bad;
   int          obs_req_bad;
   int          obs_ready_bad;
   int          obs_after_bad;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Expected outcome derived from the protocol rules (cycle 0 = acceptance).
   function automatic void model(input logic wnr, input logic [3:0] periph, input int delay,
                                 input int nack, input logic [7:0] rsrc,
                                 output int cyc, output logic err, output logic [7:0] rd);
      int n;
      n = wnr ? 13 : 5;
      rd = 8'h00;
      err = 1'b1;
      if (periph >= 4'd9) cyc = 2;
      else if (delay >= 64) cyc = n + 1 + 64;
      else if (wnr) begin cyc = n + 1 + delay + 1; err = 1'b0; end
      else if (nack >= 8) begin cyc = n + 1 + delay + 8; err = 1'b0; rd = rsrc; end
      else cyc = n + 1 + delay + nack + 1;
   endfunction

   // Issues one request and plays the responder; records what the DUT did.
   task automatic run_txn(input logic wnr, input logic [3:0] periph, input logic [3:0] addr,
                          input logic [7:0] wdata, input int delay, input int nack,
                          input logic [7:0] rsrc);
      int n, ack_start, idx;
      logic good;
      logic [8:0] one, exp_sel;
      n = wnr ? 13 : 5;
      good = periph < 4'd9;
      one = 9'd1;
      exp_sel = good ? ~(one << periph) : 9'h1FF;
      ack_start = n + 1 + delay;
      obs_cyc = -1; obs_err = 1'b0; obs_rdata = 8'h00; obs_frame = 13'd0;
      obs_csn_bad = 0; obs_req_bad = 0; obs_ready_bad = 0; obs_after_bad = 0;
      @(negedge clk);
      obs_ready0 = bus.REQ_READY;
      bus.REQ_VALID = 1'b1; bus.REQ_WNR = wnr; bus.REQ_PERIPH = periph;
      bus.REQ_ADDR = addr; bus.REQ_WDATA = wdata; bus.SCI_ACK = 1'b0;
      for (int cyc = 1; cyc <= 200 && obs_cyc < 0; cyc++) begin
         @(negedge clk);
         bus.REQ_VALID = 1'b0;
         bus.REQ_WDATA = 8'($urandom);
         if (bus.REQ_READY !== 1'b0) obs_ready_bad++;
         if (good && cyc <= n) obs_frame = {obs_frame[11:0], bus.SCI_REQ};
         else if (bus.SCI_REQ !== 1'b0) obs_req_bad++;
         if (bus.RSP_VALID === 1'b1) begin
            obs_cyc = cyc; obs_err = bus.RSP_ERROR; obs_rdata = bus.RSP_RDATA;
            if (bus.SCI_CSN !== 9'h1FF) obs_csn_bad++;
         end else if (bus.SCI_CSN !== exp_sel) obs_csn_bad++;
         bus.SCI_RESP = 1'($urandom);
         if (cyc <= n) bus.SCI_ACK = 1'($urandom);
         else if (wnr) bus.SCI_ACK = (cyc >= ack_start);
         else if (cyc >= ack_start && cyc < ack_start + nack) begin
            bus.SCI_ACK = 1'b1;
            idx = 7 - (cyc - ack_start);
            bus.SCI_RESP = rsrc[idx];
         end else bus.SCI_ACK = 1'b0;
      end
      @(negedge clk);
      if (bus.RSP_VALID !== 1'b0 || bus.REQ_READY !== 1'b1 || bus.SCI_CSN !== 9'h1FF)
         obs_after_bad++;
      bus.SCI_ACK = 1'b0;
      bus.SCI_RESP = 1'b0;
   endtask

   task automatic check_txn(input string tag, input logic wnr, input logic [3:0] periph,
                            input logic [3:0] addr, input logic [7:0] wdata, input int exp_cyc,
                            input logic exp_err, input logic [7:0] exp_rd);
      logic [12:0] exp_frame;
      exp_frame = wnr ? {wnr, addr, wdata} : {8'd0, wnr, addr};
      check({tag, ".ready_before"}, 32'(obs_ready0), 32'd1);
      check({tag, ".rsp_cycle"}, 32'(obs_cyc), 32'(exp_cyc));
      check({tag, ".rsp_error"}, 32'(obs_err), 32'(exp_err));
      check({tag, ".rsp_rdata"}, 32'(obs_rdata), 32'(exp_rd));
      if (periph < 4'd9) check({tag, ".frame"}, 32'(obs_frame), 32'(exp_frame));
      check({tag, ".csn_bad_cycles"}, 32'(obs_csn_bad), 32'd0);
      check({tag, ".req_bad_cycles"}, 32'(obs_req_bad), 32'd0);
      check({tag, ".ready_bad_cycles"}, 32'(obs_ready_bad), 32'd0);
      check({tag, ".after_rsp"}, 32'(obs_after_bad), 32'd0);
   endtask

   initial begin
      vec_t vecs[9];
      int bad_cnt, e_cyc, delay, nack, r;
      logic e_err, wnr;
      logic [7:0] e_rd, wdata, rsrc;
      logic [3:0] periph, addr;

      vecs[0] = '{1'b1, 4'd2,  4'h5, 8'hA3, 0,    0, 8'h00, 15, 1'b0, 8'h00};
      vecs[1] = '{1'b0, 4'd8,  4'h3, 8'h00, 1,    8, 8'h5C, 15, 1'b0, 8'h5C};
      vecs[2] = '{1'b0, 4'd0,  4'h0, 8'h00, 1000, 0, 8'h00, 70, 1'b1, 8'h00};
      vecs[3] = '{1'b1, 4'd9,  4'h1, 8'h55, 0,    0, 8'h00, 2,  1'b1, 8'h00};
      vecs[4] = '{1'b0, 4'd4,  4'h6, 8'h00, 0,    4, 8'hA5, 11, 1'b1, 8'h00};
      vecs[5] = '{1'b1, 4'd8,  4'hF, 8'h00, 63,   0, 8'h00, 78, 1'b0, 8'h00};
      vecs[6] = '{1'b1, 4'd1,  4'h2, 8'h3C, 64,   0, 8'h00, 78, 1'b1, 8'h00};
      vecs[7] = '{1'b0, 4'd3,  4'hC, 8'h00, 0,    8, 8'hFF, 14, 1'b0, 8'hFF};
      vecs[8] = '{1'b0, 4'd15, 4'h7, 8'h00, 0,    8, 8'h12, 2,  1'b1, 8'h00};

      n_pass = 0; n_total = 0;
      rst = 1'b1;
      bus.REQ_VALID = 1'b0; bus.REQ_WNR = 1'b0; bus.REQ_PERIPH = 4'd0;
      bus.REQ_ADDR = 4'd0; bus.REQ_WDATA = 8'd0; bus.SCI_RESP = 1'b0; bus.SCI_ACK = 1'b0;
      repeat (3) @(negedge clk);
      check("reset.csn", 32'(bus.SCI_CSN), 32'h1FF);
      check("reset.sci_req", 32'(bus.SCI_REQ), 32'd0);
      check("reset.rsp_valid", 32'(bus.RSP_VALID), 32'd0);
      check("reset.rsp_rdata", 32'(bus.RSP_RDATA), 32'd0);
      check("reset.rsp_error", 32'(bus.RSP_ERROR), 32'd0);
      check("reset.ready_in_reset", 32'(bus.REQ_READY), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("reset.ready_after", 32'(bus.REQ_READY), 32'd1);

      // ACK/RESP toggling while idle must not start anything.
      bad_cnt = 0;
      bus.SCI_ACK = 1'b1; bus.SCI_RESP = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (bus.RSP_VALID !== 1'b0 || bus.SCI_CSN !== 9'h1FF) bad_cnt++;
      end
      bus.SCI_ACK = 1'b0; bus.SCI_RESP = 1'b0;
      check("idle_ack.ignored", 32'(bad_cnt), 32'd0);

      for (int i = 0; i < 9; i++) begin
         run_txn(vecs[i].wnr, vecs[i].periph, vecs[i].addr, vecs[i].wdata,
                 vecs[i].delay, vecs[i].nack, vecs[i].rsrc);
         check_txn($sformatf("vec%0d", i), vecs[i].wnr, vecs[i].periph, vecs[i].addr,
                   vecs[i].wdata, vecs[i].exp_cyc, vecs[i].exp_err, vecs[i].exp_rd);
      end

      // Reset pulse in cycle 5 of a write.
      @(negedge clk);
      bus.REQ_VALID = 1'b1; bus.REQ_WNR = 1'b1; bus.REQ_PERIPH = 4'd2;
      bus.REQ_ADDR = 4'h5; bus.REQ_WDATA = 8'hA3;
      @(negedge clk);
      bus.REQ_VALID = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_mid.csn_before", 32'(bus.SCI_CSN), 32'h1FB);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_mid.csn", 32'(bus.SCI_CSN), 32'h1FF);
      check("rst_mid.sci_req", 32'(bus.SCI_REQ), 32'd0);
      check("rst_mid.ready", 32'(bus.REQ_READY), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      bad_cnt = 0;
      repeat (80) begin
         @(negedge clk);
         if (bus.RSP_VALID !== 1'b0 || bus.SCI_CSN !== 9'h1FF) bad_cnt++;
      end
      check("rst_mid.no_response", 32'(bad_cnt), 32'd0);
      run_txn(1'b1, 4'd2, 4'h5, 8'hA3, 2, 0, 8'h00);
      check_txn("rst_mid.next", 1'b1, 4'd2, 4'h5, 8'hA3, 17, 1'b0, 8'h00);

      for (int i = 0; i < 40; i++) begin
         wnr = 1'($urandom_range(0, 1));
         r = int'($urandom_range(0, 9));
         periph = (r == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
         addr = 4'($urandom); wdata = 8'($urandom); rsrc = 8'($urandom);
         r = int'($urandom_range(0, 9));
         if (r < 6) delay = int'($urandom_range(0, 5));
         else if (r < 9) delay = int'($urandom_range(60, 66));
         else delay = 500;
         nack = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 8;
         model(wnr, periph, delay, nack, rsrc, e_cyc, e_err, e_rd);
         run_txn(wnr, periph, addr, wdata, delay, nack, rsrc);
         check_txn($sformatf("rnd%0d", i), wnr, periph, addr, wdata, e_cyc, e_err, e_rd);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
